// File: rtl/data_mem_io.sv
// Data memory stage: word RAM plus a memory-mapped I/O page
// (LED register, synchronized switches, cycle counter, button events).
module data_mem_io #(
    parameter int unsigned       RAM_WORDS = 256,
    parameter logic [15:0]       IO_BASE   = 16'h1000,
    parameter int unsigned       SW_W      = 8,
    parameter int unsigned       BTN_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    output logic [31:0]       ReadData,
    output logic [15:0]       led
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [16:0] RAM_BYTES = 17'(RAM_WORDS * 4);
    localparam logic [15:0] A_LED     = IO_BASE;
    localparam logic [15:0] A_SW      = IO_BASE + 16'd4;
    localparam logic [15:0] A_CNT     = IO_BASE + 16'd8;
    localparam logic [15:0] A_EVT     = IO_BASE + 16'd12;

    logic [15:0]      addr;
    logic [15:0]      waddr;
    logic [AW-1:0]    idx;
    logic             is_ram, is_led, is_sw, is_cnt, is_evt;
    logic             unused_addr;

    logic [31:0]      mem [RAM_WORDS];
    logic [15:0]      led_q, led_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [BTN_W-1:0] evt_q, evt_d;
    logic [SW_W-1:0]  sw1_q, sw2_q;
    logic [BTN_W-1:0] bt1_q, bt2_q, bt3_q;
    logic [BTN_W-1:0] rise, clr;

    assign addr        = ALUResult[15:0];
    assign waddr       = {addr[15:2], 2'b00};
    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{ALUResult[31:16], ALUResult[1:0]};

    assign is_ram = ({1'b0, addr} < RAM_BYTES);
    assign is_led = (waddr == A_LED);
    assign is_sw  = (waddr == A_SW);
    assign is_cnt = (waddr == A_CNT);
    assign is_evt = (waddr == A_EVT);

    // RAM is not reset; writes are still blocked while reset is held
    always_ff @(posedge clk) begin
        if (rst && MemWrite && is_ram) begin
            mem[idx] <= WriteData;
        end
    end

    assign rise = bt2_q & ~bt3_q;
    assign clr  = (MemWrite && is_evt) ? WriteData[BTN_W-1:0] : '0;

    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q + 32'd1;
        evt_d = (evt_q & ~clr) | rise;
        if (MemWrite && is_led) begin
            led_d = WriteData[15:0];
        end
        if (MemWrite && is_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
            cnt_q <= '0;
            evt_q <= '0;
            sw1_q <= '0;
            sw2_q <= '0;
            bt1_q <= '0;
            bt2_q <= '0;
            bt3_q <= '0;
        end else begin
            led_q <= led_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            sw1_q <= sw;
            sw2_q <= sw1_q;
            bt1_q <= btn;
            bt2_q <= bt1_q;
            bt3_q <= bt2_q;
        end
    end

    always_comb begin
        ReadData = '0;
        unique case (1'b1)
            is_ram:  ReadData = mem[idx];
            is_led:  ReadData = {16'b0, led_q};
            is_sw:   ReadData = 32'(sw2_q);
            is_cnt:  ReadData = cnt_q;
            is_evt:  ReadData = 32'(evt_q);
            default: ReadData = '0;
        endcase
    end

    assign led = led_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: vector table for RAM/decode,
// hand sequences for reset, counter, synchronizers and events.
module tb_data_mem_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic [31:0] ReadData;
    logic [15:0] led;

    int n_vec = 0;
    int n_bad = 0;

    data_mem_io dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .sw        (sw),
        .btn       (btn),
        .ReadData  (ReadData),
        .led       (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        check(nm, ReadData, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h0014, 32'h12345678, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0010, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 32'h0014, 32'h0,        1'b1, 32'h12345678};
        tbl[4]  = '{1'b0, 32'h0013, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 32'h0000, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h0400, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h2000, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0400, 32'h0,        1'b1, 32'h0};
        tbl[9]  = '{1'b0, 32'h2000, 32'h0,        1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h0000, 32'h0,        1'b1, 32'hCAFEF00D};
        tbl[11] = '{1'b1, 32'h03FC, 32'h11112222, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h03FC, 32'h0,        1'b1, 32'h11112222};
        tbl[13] = '{1'b1, 32'h1000, 32'hABCD1234, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 32'h1000, 32'h0,        1'b1, 32'h00001234};
        tbl[15] = '{1'b1, 32'h1004, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 32'h1010, 32'h0,        1'b1, 32'h0};

        rst = 1'b0; MemWrite = 1'b0; ALUResult = '0;
        WriteData = '0; sw = '0; btn = '0;
        tick(); tick();
        check("rst_led", {16'b0, led}, 32'h0);
        rd("rst_cnt", 32'h1008, 32'h0);
        rd("rst_evt", 32'h100C, 32'h0);
        rd("rst_sw", 32'h1004, 32'h0);

        // counter from reset release
        rst = 1'b1;
        rd("cnt0", 32'h1008, 32'd0);
        repeat (10) tick();
        rd("cnt10", 32'h1008, 32'd10);
        repeat (40) tick();
        rd("cnt50", 32'h1008, 32'd50);
        MemWrite = 1'b1; WriteData = 32'h0;
        tick();
        rd("cnt_clr", 32'h1008, 32'd0);
        tick();
        rd("cnt_one", 32'h1008, 32'd1);

        for (int i = 0; i < 17; i++) begin
            MemWrite  = tbl[i].we;
            ALUResult = tbl[i].a;
            WriteData = tbl[i].wd;
            #1;
            if (tbl[i].chk)
                check($sformatf("vec%0d", i), ReadData, tbl[i].exp);
            tick();
        end
        MemWrite = 1'b0;
        check("led_val", {16'b0, led}, 32'h00001234);
        rd("sw_ro", 32'h1004, 32'h0);

        // async reset mid-cycle with a pending RAM write
        #2;
        MemWrite = 1'b1; ALUResult = 32'h0; WriteData = 32'h0;
        rst = 1'b0;
        #1;
        check("led_async", {16'b0, led}, 32'h0);
        tick();
        check("led_rst", {16'b0, led}, 32'h0);
        rst = 1'b1;
        rd("ram_keep", 32'h0000, 32'hCAFEF00D);
        rd("led_rd0", 32'h1000, 32'h0);

        // counter wrap
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        rd("cnt_max", 32'h1008, 32'hFFFFFFFF);
        tick();
        rd("cnt_wrap", 32'h1008, 32'h0);

        // switch synchronizer
        ALUResult = 32'h1004;
        sw = 8'hA5;
        rd("sw_e0", 32'h1004, 32'h0);
        tick();
        rd("sw_e1", 32'h1004, 32'h0);
        tick();
        rd("sw_e2", 32'h1004, 32'h000000A5);

        // button edge events
        btn = 4'b0100;
        tick();
        rd("evt_e1", 32'h100C, 32'h0);
        tick();
        rd("evt_e2", 32'h100C, 32'h0);
        tick();
        rd("evt_e3", 32'h100C, 32'h4);
        MemWrite = 1'b1; WriteData = 32'h4;
        tick();
        rd("evt_w1c", 32'h100C, 32'h0);
        tick();
        rd("evt_held", 32'h100C, 32'h0);
        btn = 4'b0000;
        repeat (4) tick();
        btn = 4'b0100;
        tick();
        tick();
        rd("evt_pre", 32'h100C, 32'h0);
        MemWrite = 1'b1; WriteData = 32'h4;
        tick();
        rd("evt_setwin", 32'h100C, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
